// File: rtl/logic_unit_pkg.sv
// Shared definitions for the two-requester logic unit arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: opcode constants, FSM state type, requester id type.
`timescale 1ns/1ps
package logic_unit_pkg;

  // Opcode encoding {i1,i0}
  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_XNOR = 2'b01;
  localparam logic [1:0] OP_OR   = 2'b10;
  localparam logic [1:0] OP_NOTA = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef logic req_id_t;

endpackage

// File: rtl/logic_unit_core.sv
// Combinational WIDTH-bit bitwise logic core (AND / XNOR / OR / NOT-a).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the output follows the inputs.
//
// Ports: a, b   operands (WIDTH)
//        op     opcode (2, see logic_unit_pkg)
//        y      result (WIDTH, no carry or extension)
`timescale 1ns/1ps
module logic_unit_core
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_XNOR: y = ~(a ^ b);
      OP_OR:   y = a | b;
      OP_NOTA: y = ~a;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one logic_unit_core between two requesters.
// Latency: req sampled at E0 -> ack pulse E0..E1, rsp_valid from E1; 1 op / 3 cycles peak.
// Backpressure: result held in RESP until rsp_ready; no acks issued while busy.
//
// Ports: clk, rst (async, active-high)
//        req0/a0/b0/op0 -> ack0, req1/a1/b1/op1 -> ack1  (capture handshakes)
//        rsp_valid/rsp_ready/rsp_data/rsp_id          (result handshake)
//        busy                                         (state != IDLE)
//        cnt0/cnt1 (8-bit saturating completion counts) only when LU_STATS_EN is defined
`timescale 1ns/1ps
module logic_unit_arbiter
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [1:0]       op0,
  output logic             ack0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic [1:0]       op1,
  output logic             ack1,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id,
  output logic             busy
`ifdef LU_STATS_EN
  ,
  output logic [7:0]       cnt0,
  output logic [7:0]       cnt1
`endif
);

  state_t           state;
  req_id_t          last_winner;
  req_id_t          id_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] core_y;

  logic    grant_vld;
  req_id_t grant_id;

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    grant_vld = req0 | req1;
    grant_id  = 1'b0;
    if (req0 && req1) grant_id = ~last_winner;
    else if (req1)    grant_id = 1'b1;
  end

  logic_unit_core #(.WIDTH(WIDTH)) u_core (
    .a  (a_q),
    .b  (b_q),
    .op (op_q),
    .y  (core_y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      last_winner <= 1'b1;
      id_q        <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= 2'b00;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_id      <= 1'b0;
      busy        <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_vld) begin
            a_q         <= grant_id ? a1 : a0;
            b_q         <= grant_id ? b1 : b0;
            op_q        <= grant_id ? op1 : op0;
            id_q        <= grant_id;
            last_winner <= grant_id;
            ack0        <= ~grant_id;
            ack1        <= grant_id;
            busy        <= 1'b1;
            state       <= EXEC;
          end
        end
        EXEC: begin
          rsp_data  <= core_y;
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          // Data and id simply hold while the consumer stalls.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef LU_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0 <= 8'd0;
      cnt1 <= 8'd0;
    end else if (state == RESP && rsp_ready) begin
      if (!id_q && cnt0 != 8'hFF) cnt0 <= cnt0 + 8'd1;
      if ( id_q && cnt1 != 8'hFF) cnt1 <= cnt1 + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed self-checking bench for logic_unit_arbiter (WIDTH=2).
// Inputs change and outputs are sampled 1ns after each rising edge.
// Counter checks are compiled only when LU_STATS_EN is defined.
`timescale 1ns/1ps
module tb_logic_unit_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1, rsp_ready;
  logic [1:0] a0, b0, op0, a1, b1, op1;
  logic       ack0, ack1, rsp_valid, rsp_id, busy;
  logic [1:0] rsp_data;
`ifdef LU_STATS_EN
  logic [7:0] cnt0, cnt1;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  logic_unit_arbiter #(.WIDTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .a0        (a0),
    .b0        (b0),
    .op0       (op0),
    .ack0      (ack0),
    .req1      (req1),
    .a1        (a1),
    .b1        (b1),
    .op1       (op1),
    .ack1      (ack1),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy)
`ifdef LU_STATS_EN
    ,
    .cnt0      (cnt0),
    .cnt1      (cnt1)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // One complete operation from IDLE with a single requester and rsp_ready high.
  task automatic do_op(input logic id, input logic [1:0] a, input logic [1:0] b,
                       input logic [1:0] op, input logic [1:0] exp, input string tag);
    if (id) begin req1 = 1'b1; a1 = a; b1 = b; op1 = op; end
    else    begin req0 = 1'b1; a0 = a; b0 = b; op0 = op; end
    rsp_ready = 1'b1;
    step();
    check({tag, "_ack"}, id ? ack1 : ack0, 1'b1);
    req0 = 1'b0;
    req1 = 1'b0;
    step();
    check({tag, "_vld"},  rsp_valid, 1'b1);
    check({tag, "_data"}, rsp_data, exp);
    check({tag, "_id"},   rsp_id, id);
    step();
    check({tag, "_done"}, rsp_valid, 1'b0);
  endtask

  logic fair_exp;
  logic fair_last;
  int   grants;

  initial begin
    rst = 1'b1;
    req0 = 1'b1; req1 = 1'b1; rsp_ready = 1'b0;
    a0 = 2'b00; b0 = 2'b00; op0 = 2'b00;
    a1 = 2'b00; b1 = 2'b00; op1 = 2'b00;

    // Reset hold with both requests asserted
    step(); step(); step();
    check("rst_ack0",  ack0, 1'b0);
    check("rst_ack1",  ack1, 1'b0);
    check("rst_vld",   rsp_valid, 1'b0);
    check("rst_busy",  busy, 1'b0);
    check("rst_data",  rsp_data, 2'b00);
    check("rst_id",    rsp_id, 1'b0);
`ifdef LU_STATS_EN
    check("rst_cnt0", cnt0, 8'd0);
    check("rst_cnt1", cnt1, 8'd0);
`endif
    req0 = 1'b0; req1 = 1'b0;
    rst = 1'b0;
    step();

    // Single requests: a=10, b=11
    do_op(1'b0, 2'b10, 2'b11, 2'b10, 2'b11, "or");
    do_op(1'b0, 2'b10, 2'b11, 2'b01, 2'b10, "xnor");
    do_op(1'b0, 2'b10, 2'b11, 2'b00, 2'b10, "and");
    do_op(1'b0, 2'b10, 2'b11, 2'b11, 2'b01, "nota");
    do_op(1'b1, 2'b01, 2'b00, 2'b10, 2'b01, "r1_or");
    check("idle_busy", busy, 1'b0);

    // Tie and fairness from reset: grants 0,1,0,1
    do_reset();
    a0 = 2'b01; b0 = 2'b01; op0 = 2'b00;
    a1 = 2'b10; b1 = 2'b00; op1 = 2'b10;
    req0 = 1'b1; req1 = 1'b1; rsp_ready = 1'b1;
    fair_exp = 1'b0; fair_last = 1'b0; grants = 0;
    for (int cyc = 0; cyc < 40 && grants < 4; cyc++) begin
      step();
      if (ack0 || ack1) begin
        check("fair_grant",  ack1, fair_exp);
        check("fair_onehot", ack0 ^ ack1, 1'b1);
        fair_last = ack1;
        if (ack1) req1 = 1'b0; else req0 = 1'b0;
        fair_exp = ~fair_exp;
        grants++;
      end else begin
        req0 = 1'b1; req1 = 1'b1;
      end
      if (rsp_valid) begin
        check("fair_id",   rsp_id, fair_last);
        check("fair_data", rsp_data, fair_last ? 2'b10 : 2'b01);
      end
    end
    check("fair_count", grants, 4);
    req0 = 1'b0; req1 = 1'b0;
    step(); step(); step();

    // Back-pressure: result 01 held while rsp_ready low, req1 pending
    do_reset();
    rsp_ready = 1'b0;
    req0 = 1'b1; a0 = 2'b10; b0 = 2'b00; op0 = 2'b11;
    step();
    check("bp_ack0", ack0, 1'b1);
    req0 = 1'b0;
    req1 = 1'b1; a1 = 2'b11; b1 = 2'b00; op1 = 2'b10;
    step();
    check("bp_vld_rise", rsp_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_vld",  rsp_valid, 1'b1);
      check("bp_data", rsp_data, 2'b01);
      check("bp_id",   rsp_id, 1'b0);
      check("bp_noack", {ack0, ack1}, 2'b00);
    end
    rsp_ready = 1'b1;
    step();
    check("bp_vld_drop", rsp_valid, 1'b0);
    check("bp_idle",     busy, 1'b0);
    check("bp_noack1",   ack1, 1'b0);
    step();
    check("bp_ack1", ack1, 1'b1);
    req1 = 1'b0;
    a1 = 2'b00;  // captured operand must not follow this change
    step();
    check("bp_r1_vld",  rsp_valid, 1'b1);
    check("bp_r1_data", rsp_data, 2'b11);
    check("bp_r1_id",   rsp_id, 1'b1);
    step();

    // Reset mid-op: capture for requester 1, then asynchronous reset in EXEC
    req1 = 1'b1; a1 = 2'b01; b1 = 2'b01; op1 = 2'b00;
    step();
    check("mid_ack1", ack1, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("mid_async_ack1", ack1, 1'b0);
    check("mid_async_busy", busy, 1'b0);
    req1 = 1'b0;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("mid_no_rsp", rsp_valid, 1'b0);
    end
    req0 = 1'b1; req1 = 1'b1;
    a0 = 2'b11; b0 = 2'b10; op0 = 2'b01;
    step();
    check("mid_tie_ack0", ack0, 1'b1);
    check("mid_tie_ack1", ack1, 1'b0);
    req0 = 1'b0; req1 = 1'b0;
    step();
    check("mid_tie_data", rsp_data, 2'b10);
    step();

`ifdef LU_STATS_EN
    do_reset();
    do_op(1'b0, 2'b10, 2'b11, 2'b10, 2'b11, "st_a");
    do_op(1'b0, 2'b10, 2'b11, 2'b00, 2'b10, "st_b");
    do_op(1'b1, 2'b01, 2'b10, 2'b10, 2'b11, "st_c");
    do_op(1'b0, 2'b10, 2'b11, 2'b11, 2'b01, "st_d");
    check("cnt0_3", cnt0, 8'd3);
    check("cnt1_1", cnt1, 8'd1);
    for (int i = 0; i < 300; i++)
      do_op(1'b0, 2'b01, 2'b10, 2'b10, 2'b11, "st_sat");
    check("cnt0_sat", cnt0, 8'd255);
    check("cnt1_hold", cnt1, 8'd1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
